// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: programmable decision-tree classifier that walks a writable
// node table one level per clock and reports a class index (or an abort flag
// when the walk exceeds MAX_DEPTH nodes).
// Node word layout: {leaf, feat_idx[FIW], thr[FEAT_W], left[NODE_AW]}.
// Optional feature macro: DTREE_LEAF_BYPASS_EN -- a sample whose root node is a
// leaf goes straight from IDLE to DONE, saving one cycle of latency.
module dtree_seq_eval #(
    parameter int FEAT_W    = 8,
    parameter int N_FEAT    = 16,
    parameter int CLASS_W   = 4,
    parameter int NODE_AW   = 6,
    parameter int MAX_DEPTH = 8,
    parameter int FIW       = (N_FEAT > 1) ? $clog2(N_FEAT) : 1,
    parameter int NODE_W    = 1 + FIW + FEAT_W + NODE_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [NODE_AW-1:0]       cfg_addr,
    input  logic [NODE_W-1:0]        cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err
);

    localparam int NODES = 2 ** NODE_AW;
    localparam int DW    = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [NODE_W-1:0]         tbl_r [NODES];
    logic [N_FEAT*FEAT_W-1:0]  feat_r;
    logic [NODE_AW-1:0]        node_r;
    logic [DW-1:0]             depth_r;
    logic                      run_r;
    logic                      out_valid_r;
    logic [CLASS_W-1:0]        out_class_r;
    logic                      out_err_r;

    logic                      in_ready_s;
    logic                      accept_s;
    logic                      tbl_we_s;
    logic                      out_valid_nxt_s;
    logic [CLASS_W-1:0]        out_class_nxt_s;
    logic                      out_err_nxt_s;

    logic [NODE_W-1:0]         cur_s;
    logic                      cur_leaf_s;
    logic [FIW-1:0]            cur_idx_s;
    logic [FEAT_W-1:0]         cur_thr_s;
    logic [NODE_AW-1:0]        cur_left_s;
    logic [FEAT_W-1:0]         cur_feat_s;
    logic [NODE_AW-1:0]        next_node_s;
    logic                      last_s;
    logic                      root_leaf_s;
    logic [CLASS_W-1:0]        root_class_s;

    // Feature mux; indices past the end of the vector read as zero.
    function automatic logic [FEAT_W-1:0] feat_pick(input logic [N_FEAT*FEAT_W-1:0] fv,
                                                    input logic [FIW-1:0]           idx);
        logic [FEAT_W-1:0] r;
        r = {FEAT_W{1'b0}};
        for (int i = 0; i < N_FEAT; i++) begin
            r = (idx == FIW'(i)) ? fv[i*FEAT_W +: FEAT_W] : r;
        end
        return r;
    endfunction

    // Decode of the node currently being visited and of the root node.
    always_comb begin
        cur_s        = tbl_r[node_r];
        cur_leaf_s   = cur_s[NODE_W-1];
        cur_idx_s    = cur_s[NODE_AW+FEAT_W +: FIW];
        cur_thr_s    = cur_s[NODE_AW +: FEAT_W];
        cur_left_s   = cur_s[NODE_AW-1:0];
        cur_feat_s   = feat_pick(feat_r, cur_idx_s);
        // Right child is left+1 and wraps around the table naturally.
        next_node_s  = (cur_feat_s <= cur_thr_s) ? cur_left_s : (cur_left_s + {{(NODE_AW-1){1'b0}}, 1'b1});
        last_s       = ((depth_r + DW'(1)) == DW'(MAX_DEPTH));
        root_leaf_s  = tbl_r[0][NODE_W-1];
        root_class_s = tbl_r[0][NODE_AW +: CLASS_W];
    end

    // Handshake and table-write qualification; writes are blocked while busy.
    always_comb begin
        in_ready_s = run_r & (state_r == ST_IDLE) & ~cfg_we;
        accept_s   = in_valid & in_ready_s;
        tbl_we_s   = cfg_we & (state_r == ST_IDLE);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
`ifdef DTREE_LEAF_BYPASS_EN
                    state_nxt_s = root_leaf_s ? ST_DONE : ST_WALK;
`else
                    state_nxt_s = ST_WALK;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (cur_leaf_s || last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WALK;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Result outputs: set when the walk resolves, held through backpressure.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_class_nxt_s = out_class_r;
        out_err_nxt_s   = out_err_r;
        case (state_r)
            ST_IDLE: begin
`ifdef DTREE_LEAF_BYPASS_EN
                if (accept_s && root_leaf_s) begin
                    out_valid_nxt_s = 1'b1;
                    out_class_nxt_s = root_class_s;
                    out_err_nxt_s   = 1'b0;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
`else
                out_valid_nxt_s = 1'b0;
`endif
            end
            ST_WALK: begin
                if (cur_leaf_s) begin
                    out_valid_nxt_s = 1'b1;
                    out_class_nxt_s = cur_thr_s[CLASS_W-1:0];
                    out_err_nxt_s   = 1'b0;
                end else if (last_s) begin
                    out_valid_nxt_s = 1'b1;
                    out_class_nxt_s = {CLASS_W{1'b0}};
                    out_err_nxt_s   = 1'b1;
                end else begin
                    out_valid_nxt_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                out_valid_nxt_s = 1'b0;
                out_class_nxt_s = {CLASS_W{1'b0}};
                out_err_nxt_s   = 1'b0;
            end
        endcase
    end

    // FSM state register and post-reset run flag (keeps in_ready low in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
        end
    end

    // Node table; cleared by reset, written only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NODES; i++) begin
                tbl_r[i] <= {NODE_W{1'b0}};
            end
        end else if (tbl_we_s) begin
            tbl_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Walk datapath: latched features, current node and depth counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_r  <= {(N_FEAT*FEAT_W){1'b0}};
            node_r  <= {NODE_AW{1'b0}};
            depth_r <= {DW{1'b0}};
        end else if (accept_s) begin
            feat_r  <= in_feat;
            node_r  <= {NODE_AW{1'b0}};
            depth_r <= {DW{1'b0}};
        end else if ((state_r == ST_WALK) && !cur_leaf_s && !last_s) begin
            node_r  <= next_node_s;
            depth_r <= depth_r + DW'(1);
        end
    end

    // Registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_class_r <= {CLASS_W{1'b0}};
            out_err_r   <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            out_class_r <= out_class_nxt_s;
            out_err_r   <= out_err_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_class = out_class_r;
    assign out_err   = out_err_r;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Self-checking bench for dtree_seq_eval. N_FEAT is 12 here so that feature
// indices 12..15 are encodable and the out-of-range path can be exercised.
module tb_dtree_seq_eval;

    localparam int FEAT_W    = 8;
    localparam int N_FEAT    = 12;
    localparam int CLASS_W   = 4;
    localparam int NODE_AW   = 6;
    localparam int MAX_DEPTH = 8;
    localparam int FIW       = 4;
    localparam int NODE_W    = 1 + FIW + FEAT_W + NODE_AW;
    localparam int NODES     = 64;
    localparam int FV        = N_FEAT * FEAT_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [NODE_W-1:0]  cfg_wdata;
    logic               in_valid;
    logic               in_ready;
    logic [FV-1:0]      in_feat;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_err;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [NODE_W-1:0] mtbl [NODES];

    dtree_seq_eval #(
        .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .CLASS_W(CLASS_W),
        .NODE_AW(NODE_AW), .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .in_valid(in_valid), .in_ready(in_ready),
        .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NODE_W-1:0] mk(input logic leaf, input logic [FIW-1:0] idx,
                                             input logic [FEAT_W-1:0] thr, input logic [NODE_AW-1:0] left);
        return {leaf, idx, thr, left};
    endfunction

    function automatic logic [FV-1:0] rand_feat();
        logic [FV-1:0] f;
        for (int i = 0; i < N_FEAT; i++) f[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
        return f;
    endfunction

    // Reference: walk the tree as described, one visited node per loop pass.
    function automatic void model(input logic [FV-1:0] f, output logic [CLASS_W-1:0] cls,
                                  output logic err, output int lvl);
        int n, idx, fv, thr, left;
        logic [NODE_W-1:0] w;
        n = 0; cls = '0; err = 1'b1; lvl = MAX_DEPTH - 1;
        for (int d = 0; d < MAX_DEPTH; d++) begin
            w = mtbl[n];
            if (w[NODE_W-1]) begin
                cls = w[NODE_AW +: CLASS_W]; err = 1'b0; lvl = d;
                return;
            end
            idx  = int'(w[NODE_AW+FEAT_W +: FIW]);
            thr  = int'(w[NODE_AW +: FEAT_W]);
            left = int'(w[NODE_AW-1:0]);
            fv = 0;
            if (idx < N_FEAT) fv = int'(f[idx*FEAT_W +: FEAT_W]);
            n = (fv <= thr) ? left : (left + 1) % NODES;
        end
    endfunction

    // Clock edges from the accepting edge until out_valid is seen.
    function automatic int exp_edges(input logic err, input int lvl);
`ifdef DTREE_LEAF_BYPASS_EN
        if (!err && lvl == 0) return 0;
`endif
        return lvl + 1;
    endfunction

    task automatic cfg_write(input int addr, input logic [NODE_W-1:0] w);
        cfg_we = 1'b1; cfg_addr = NODE_AW'(addr); cfg_wdata = w;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        mtbl[addr] = w;
    endtask

    // Present a sample and return just after the accepting edge.
    task automatic send(input logic [FV-1:0] f);
        int k;
        in_feat = f; in_valid = 1'b1; k = 0;
        #1;
        while (in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #2; k++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL accept_timeout in_ready=%b expected=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_feat  = rand_feat();
    endtask

    task automatic wait_result(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release out_valid=%b expected=0", out_valid);
        end
    endtask

    task automatic run_one(input string name, input logic [FV-1:0] f, input int hold);
        logic [CLASS_W-1:0] ecls; logic eerr; int lvl, edges;
        model(f, ecls, eerr, lvl);
        send(f);
        wait_result(edges);
        n_cmp++;
        if (edges != exp_edges(eerr, lvl)) begin
            n_fail++; $display("FAIL %s latency got=%0d expected=%0d", name, edges, exp_edges(eerr, lvl));
        end
        n_cmp++;
        if (out_class !== ecls || out_err !== eerr) begin
            n_fail++; $display("FAIL %s result class=%0d err=%b expected class=%0d err=%b",
                               name, out_class, out_err, ecls, eerr);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_class !== ecls) begin
                n_fail++; $display("FAIL %s hold valid=%b class=%0d expected valid=1 class=%0d",
                                   name, out_valid, out_class, ecls);
            end
        end
        release_out();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_class !== 4'd0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL reset ready=%b valid=%b class=%0d err=%b expected all 0",
                               in_ready, out_valid, out_class, out_err);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NODES; i++) mtbl[i] = '0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL idle_ready in_ready=%b expected=1", in_ready);
        end
    endtask

    task automatic test_reset_walk();
        int edges;
        send('0);
        wait_result(edges);
        n_cmp++;
        if (edges != MAX_DEPTH || out_err !== 1'b1 || out_class !== 4'd0) begin
            n_fail++; $display("FAIL depth_abort edges=%0d err=%b class=%0d expected edges=%0d err=1 class=0",
                               edges, out_err, out_class, MAX_DEPTH);
        end
        release_out();
    endtask

    task automatic test_two_level();
        logic [FV-1:0] f; logic [FEAT_W-1:0] v; logic [CLASS_W-1:0] ec; int edges;
        cfg_write(0, mk(1'b0, 4'd3, 8'h7F, 6'd1));
        cfg_write(1, mk(1'b1, 4'd0, 8'h05, 6'd0));
        cfg_write(2, mk(1'b1, 4'd0, 8'h09, 6'd0));
        for (int k = 0; k < 2; k++) begin
            v  = (k == 0) ? 8'h7F : 8'h80;
            ec = (k == 0) ? 4'd5 : 4'd9;
            f = rand_feat(); f[3*FEAT_W +: FEAT_W] = v;
            send(f);
            wait_result(edges);
            n_cmp++;
            if (edges != 2 || out_class !== ec || out_err !== 1'b0) begin
                n_fail++; $display("FAIL two_level feat3=%h edges=%0d class=%0d err=%b expected edges=2 class=%0d err=0",
                                   v, edges, out_class, out_err, ec);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [FV-1:0] f; int edges;
        f = rand_feat(); f[3*FEAT_W +: FEAT_W] = 8'hC3;
        send(f);
        wait_result(edges);
        repeat (10) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_class !== 4'd9 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL backpressure valid=%b class=%0d ready=%b expected valid=1 class=9 ready=0",
                                   out_valid, out_class, in_ready);
            end
        end
        release_out();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_release in_ready=%b expected=1", in_ready);
        end
    endtask

    task automatic test_collision();
        logic [FV-1:0] f;
        f = rand_feat(); f[3*FEAT_W +: FEAT_W] = 8'h80;
        cfg_we = 1'b1; cfg_addr = 6'd2; cfg_wdata = mk(1'b1, 4'd0, 8'h0C, 6'd0);
        in_valid = 1'b1; in_feat = f;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL collision_ready in_ready=%b expected=0", in_ready);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        mtbl[2] = mk(1'b1, 4'd0, 8'h0C, 6'd0);
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL collision_accepted out_valid=%b expected=0", out_valid);
            end
        end
        run_one("collision_write", f, 0);
    endtask

    task automatic test_busy_write();
        logic [FV-1:0] f; int edges;
        f = rand_feat(); f[3*FEAT_W +: FEAT_W] = 8'h7F;
        send(f);
        cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = mk(1'b1, 4'd0, 8'h0E, 6'd0);
        wait_result(edges);
        n_cmp++;
        if (out_class !== 4'd5 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL busy_write class=%0d err=%b expected class=5 err=0", out_class, out_err);
        end
        repeat (2) @(posedge clk);
        #1;
        cfg_we = 1'b0;
        release_out();
        run_one("busy_write_ignored", f, 0);
    endtask

    task automatic test_wrap();
        logic [FV-1:0] f;
        cfg_write(0, mk(1'b0, 4'd0, 8'h10, 6'd63));
        cfg_write(63, mk(1'b1, 4'd0, 8'h07, 6'd0));
        f = rand_feat(); f[0 +: FEAT_W] = 8'h11;
        run_one("wrap_right", f, 1);
        f = rand_feat(); f[0 +: FEAT_W] = 8'h10;
        run_one("wrap_left_leaf", f, 0);
    endtask

    task automatic test_out_of_range();
        logic [FV-1:0] f;
        f = '1;
        cfg_write(0, mk(1'b0, 4'd14, 8'h00, 6'd1));
        run_one("feat_out_of_range", f, 0);
        cfg_write(0, mk(1'b0, 4'd11, 8'h00, 6'd1));
        run_one("feat_last_in_range", f, 0);
    endtask

    task automatic test_bypass();
        int edges, exp_e;
`ifdef DTREE_LEAF_BYPASS_EN
        exp_e = 0;
`else
        exp_e = 1;
`endif
        cfg_write(0, mk(1'b1, 4'd7, 8'h33, 6'd9));
        send(rand_feat());
        wait_result(edges);
        n_cmp++;
        if (edges != exp_e || out_class !== 4'd3 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL root_leaf edges=%0d class=%0d err=%b expected edges=%0d class=3 err=0",
                               edges, out_class, out_err, exp_e);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [NODE_W-1:0] w;
        for (int a = 0; a < NODES; a++) begin
            w = NODE_W'($urandom);
            w[NODE_W-1] = ($urandom_range(0, 3) == 0);
            cfg_write(a, w);
        end
        for (int s = 0; s < 30; s++) begin
            run_one("random", rand_feat(), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_midwalk();
        cfg_write(0, mk(1'b0, 4'd0, 8'hFF, 6'd1));
        cfg_write(1, mk(1'b0, 4'd0, 8'hFF, 6'd1));
        send(rand_feat());
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_class !== 4'd0 || out_err !== 1'b0) begin
            n_fail++; $display("FAIL midwalk_reset ready=%b valid=%b class=%0d err=%b expected all 0",
                               in_ready, out_valid, out_class, out_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NODES; i++) mtbl[i] = '0;
        @(posedge clk); #1;
        cfg_write(1, mk(1'b1, 4'd0, 8'h06, 6'd0));
        run_one("table_cleared", rand_feat(), 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
        test_reset();
        test_reset_walk();
        test_two_level();
        test_backpressure();
        test_collision();
        test_busy_write();
        test_wrap();
        test_out_of_range();
        test_bypass();
        test_random();
        test_reset_midwalk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
